// File: rtl/evo_array_eval.sv
`default_nettype none
// ============================================================================
// Module   : evo_array_eval
// Purpose  : Runtime-configurable evolvable gate array. A serially loaded
//            genome selects each gate's function and two sources (primary
//            inputs or gate state). Gate feedback runs through synchronous
//            state registers, so each evaluation is a fixed number of
//            concurrent updates and yields an output vector plus a
//            stability flag.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            cfg_valid/cfg_bit   - genome bit stream, MSB first
//            cfg_ready           - bit accepted when cfg_valid & cfg_ready
//            cfg_done            - one-cycle pulse on the final genome bit
//            configured          - a complete genome is held
//            in, eval_start      - primary inputs and start request
//            busy                - evaluation in progress
//            result_valid        - one-cycle pulse with result/stable
//            result, stable      - selected outputs, last update unchanged
//            toggle_cnt          - (EVO_TOGGLE_COUNT_EN only) updates in
//                                  which output 0 changed
// Options  : `define EVO_TOGGLE_COUNT_EN adds the toggle_cnt port/counter.
// Revision : 1.0 - initial release
// ============================================================================
module evo_array_eval #(
  parameter int NUM_INPUTS    = 2,
  parameter int NUM_GATES     = 7,
  parameter int NUM_OUTPUTS   = 1,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_valid,
  input  logic                   cfg_bit,
  output logic                   cfg_ready,
  output logic                   cfg_done,
  output logic                   configured,
  input  logic [NUM_INPUTS-1:0]  in,
  input  logic                   eval_start,
  output logic                   busy,
  output logic                   result_valid,
  output logic [NUM_OUTPUTS-1:0] result,
  output logic                   stable
`ifdef EVO_TOGGLE_COUNT_EN
  ,
  output logic [$clog2(SETTLE_CYCLES+1)-1:0] toggle_cnt
`endif
);

  localparam int N     = NUM_INPUTS + NUM_GATES;
  localparam int SEL_W = $clog2(N);
  localparam int GW    = 3 + 2 * SEL_W;
  localparam int G     = NUM_GATES * GW + NUM_OUTPUTS * SEL_W;
  localparam int NP    = 1 << SEL_W;             // full select space
  localparam int CW    = $clog2(SETTLE_CYCLES + 1);
  localparam int BW    = $clog2(G + 1);

  localparam logic [1:0] S_UNCFG = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;
  localparam logic [1:0] S_EVAL  = 2'd3;

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bitcnt;
  logic [BW-1:0]         bitcnt_inc;
  logic [NUM_GATES-1:0]  w;
  logic [NUM_GATES-1:0]  w_next;
  logic [G-1:0]          genome;
  logic [NUM_INPUTS-1:0] in_q;
  logic [NP-1:0]         cur_pad;
  logic [NP-1:0]         nxt_pad;
  logic [NUM_OUTPUTS-1:0] sel_next;
  logic                  cfg_accept;

  function automatic logic gate_fn(input logic [2:0] f, input logic a, input logic b);
    case (f)
      3'd0:    gate_fn = a & b;
      3'd1:    gate_fn = a | b;
      3'd2:    gate_fn = ~(a & b);
      3'd3:    gate_fn = ~(a | b);
      3'd4:    gate_fn = a ^ b;
      3'd5:    gate_fn = ~(a ^ b);
      3'd6:    gate_fn = ~a;
      default: gate_fn = a;
    endcase
  endfunction

  assign cfg_ready  = (state != S_EVAL);
  assign busy       = (state == S_EVAL);
  assign cfg_accept = cfg_valid & cfg_ready;

  // Source vectors padded to the full select range; indices >= N read 0.
  always_comb begin
    cur_pad        = '0;
    cur_pad[N-1:0] = {w, in_q};
  end

  always_comb begin
    nxt_pad        = '0;
    nxt_pad[N-1:0] = {w_next, in_q};
  end

  generate
    for (genvar k = 0; k < NUM_GATES; k++) begin : g_gate
      logic [2:0]       func;
      logic [SEL_W-1:0] src_a;
      logic [SEL_W-1:0] src_b;
      assign func      = genome[k*GW +: 3];
      assign src_a     = genome[k*GW+3 +: SEL_W];
      assign src_b     = genome[k*GW+3+SEL_W +: SEL_W];
      assign w_next[k] = gate_fn(func, cur_pad[src_a], cur_pad[src_b]);
    end
    for (genvar j = 0; j < NUM_OUTPUTS; j++) begin : g_out
      assign sel_next[j] = nxt_pad[genome[NUM_GATES*GW + j*SEL_W +: SEL_W]];
    end
  endgenerate

`ifdef EVO_TOGGLE_COUNT_EN
  logic sel_cur0;
  assign sel_cur0 = cur_pad[genome[NUM_GATES*GW +: SEL_W]];
`endif

  // A reload from READY restarts the bit count; otherwise it continues.
  assign bitcnt_inc = ((state == S_LOAD) ? bitcnt : '0) + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_UNCFG;
      cnt          <= '0;
      bitcnt       <= '0;
      w            <= '0;
      genome       <= '0;
      in_q         <= '0;
      cfg_done     <= 1'b0;
      configured   <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      stable       <= 1'b0;
`ifdef EVO_TOGGLE_COUNT_EN
      toggle_cnt   <= '0;
`endif
    end else begin
      cfg_done     <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        S_UNCFG, S_LOAD, S_READY: begin
          if (cfg_accept) begin
            genome <= {genome[G-2:0], cfg_bit};
            bitcnt <= bitcnt_inc;
            if (bitcnt_inc == BW'(G)) begin
              configured <= 1'b1;
              cfg_done   <= 1'b1;
              state      <= S_READY;
            end else begin
              configured <= 1'b0;
              state      <= S_LOAD;
            end
          end else if (state == S_READY && eval_start) begin
            state <= S_EVAL;
            in_q  <= in;
            w     <= '0;
            cnt   <= '0;
`ifdef EVO_TOGGLE_COUNT_EN
            toggle_cnt <= '0;
`endif
          end
        end
        S_EVAL: begin
          w   <= w_next;
          cnt <= cnt + 1'b1;
`ifdef EVO_TOGGLE_COUNT_EN
          if (sel_cur0 != sel_next[0]) toggle_cnt <= toggle_cnt + 1'b1;
`endif
          // Final update: capture outputs of the new state and compare it
          // against the previous state for the oscillation flag.
          if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            result       <= sel_next;
            stable       <= (w_next == w);
            result_valid <= 1'b1;
            state        <= S_READY;
          end
        end
        default: state <= S_UNCFG;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_evo_array_eval.sv
`default_nettype none
// ============================================================================
// Module   : tb_evo_array_eval
// Purpose  : Self-checking bench for evo_array_eval. A genome-level model
//            computes evaluation results from the gate rules; a compare
//            process checks DUT outputs every cycle, and directed tests add
//            literal expectations.
// Options  : honours EVO_TOGGLE_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_evo_array_eval;

  localparam int NI    = 2;
  localparam int NG    = 7;
  localparam int NO    = 1;
  localparam int S     = 16;
  localparam int N     = NI + NG;
  localparam int SEL_W = $clog2(N);
  localparam int GW    = 3 + 2 * SEL_W;
  localparam int G     = NG * GW + NO * SEL_W;
  localparam int TW    = $clog2(S + 1);

  logic          clk;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_bit;
  logic          cfg_ready;
  logic          cfg_done;
  logic          configured;
  logic [NI-1:0] in_v;
  logic          eval_start;
  logic          busy;
  logic          result_valid;
  logic [NO-1:0] result;
  logic          stable;
`ifdef EVO_TOGGLE_COUNT_EN
  logic [TW-1:0] toggle_cnt;
`endif

  evo_array_eval #(
    .NUM_INPUTS(NI), .NUM_GATES(NG), .NUM_OUTPUTS(NO), .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done), .configured(configured),
    .in(in_v), .eval_start(eval_start), .busy(busy),
    .result_valid(result_valid), .result(result), .stable(stable)
`ifdef EVO_TOGGLE_COUNT_EN
    , .toggle_cnt(toggle_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // ---------------- genome-level model ----------------
  function automatic logic src_val(input logic [SEL_W-1:0] idx, input logic [NI-1:0] iv,
                                   input logic [NG-1:0] wv);
    int i;
    i = int'(idx);
    if (i < NI) return iv[i];
    else if (i < N) return wv[i-NI];
    else return 1'b0;
  endfunction

  function automatic logic gate(input logic [2:0] f, input logic a, input logic b);
    case (f)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~(a & b);
      3'd3: return ~(a | b);
      3'd4: return a ^ b;
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  function automatic void model_eval(input logic [G-1:0] gn, input logic [NI-1:0] iv,
                                     output logic [NO-1:0] res, output logic st, output int tog);
    logic [NG-1:0]    wv, nw;
    logic [GW-1:0]    fld;
    logic [SEL_W-1:0] o0;
    wv  = '0;
    nw  = '0;
    tog = 0;
    st  = 1'b0;
    o0  = gn[NG*GW +: SEL_W];
    for (int step = 0; step < S; step++) begin
      for (int k = 0; k < NG; k++) begin
        fld   = gn[k*GW +: GW];
        nw[k] = gate(fld[2:0], src_val(fld[SEL_W+2:3], iv, wv),
                     src_val(fld[2*SEL_W+2:SEL_W+3], iv, wv));
      end
      if (src_val(o0, iv, nw) != src_val(o0, iv, wv)) tog++;
      st = (nw == wv);
      wv = nw;
    end
    for (int j = 0; j < NO; j++) res[j] = src_val(gn[NG*GW + j*SEL_W +: SEL_W], iv, wv);
  endfunction

  function automatic logic [G-1:0] mk(input int f0, input int a0, input int b0,
                                      input int fr, input int ar, input int br, input int osel);
    logic [G-1:0] g;
    g = '0;
    for (int k = 0; k < NG; k++) begin
      if (k == 0) g[k*GW +: GW] = {SEL_W'(b0), SEL_W'(a0), 3'(f0)};
      else        g[k*GW +: GW] = {SEL_W'(br), SEL_W'(ar), 3'(fr)};
    end
    g[NG*GW +: SEL_W] = SEL_W'(osel);
    return g;
  endfunction

  // Cycle-level expectation tracker, advanced on every active edge.
  int            cyc = 0;
  int            due = 0;
  bit            m_eval = 0;
  bit            m_have = 0;
  int            m_nbits = 0;
  logic [G-1:0]  m_gen = '0;
  logic [NO-1:0] e_res = '0, p_res;
  logic          e_st = 1'b0, p_st;
  bit            e_rv = 0, e_done = 0;
  int            e_tog = 0, p_tog;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_eval = 0; m_have = 0; m_nbits = 0; m_gen = '0;
      e_res = '0; e_st = 1'b0; e_rv = 0; e_done = 0; e_tog = 0;
    end else begin
      e_rv   = 0;
      e_done = 0;
      if (m_eval) begin
        if (cyc == due) begin
          m_eval = 0; e_rv = 1; e_res = p_res; e_st = p_st; e_tog = p_tog;
        end
      end else if (cfg_valid) begin
        if (m_have) begin m_have = 0; m_nbits = 0; end
        m_gen = {m_gen[G-2:0], cfg_bit};
        m_nbits++;
        if (m_nbits == G) begin m_have = 1; e_done = 1; end
      end else if (eval_start && m_have) begin
        m_eval = 1;
        due    = cyc + S;
        e_tog  = 0;
        model_eval(m_gen, in_v, p_res, p_st, p_tog);
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_eval));
    chk("cfg_ready", 32'(cfg_ready), 32'(!m_eval));
    chk("configured", 32'(configured), 32'(m_have));
    chk("cfg_done", 32'(cfg_done), 32'(e_done));
    chk("result_valid", 32'(result_valid), 32'(e_rv));
    chk("result", 32'(result), 32'(e_res));
    chk("stable", 32'(stable), 32'(e_st));
`ifdef EVO_TOGGLE_COUNT_EN
    if (!m_eval) chk("toggle_cnt", 32'(toggle_cnt), 32'(e_tog));
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic load_bits(input logic [G-1:0] g, input int top, input int exp_n);
    int n, found;
    n = 0;
    found = -1;
    for (int i = top; i >= 0; i--) begin
      cfg_valid = 1'b1;
      cfg_bit   = g[i];
      @(posedge clk); #1;
      n++;
      if (cfg_done && found < 0) found = n;
    end
    cfg_valid = 1'b0;
    chk("bits_until_cfg_done", 32'(found), 32'(exp_n));
    chk("configured_after_load", 32'(configured), 32'd1);
  endtask

  task automatic run_eval(input logic [NI-1:0] iv, input logic r, input logic st, input int tg);
    int lat;
    in_v = iv;
    eval_start = 1'b1;
    @(posedge clk); #1;
    eval_start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    while (!result_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("result_latency", 32'(lat), 32'd16);
    chk("result_literal", 32'(result), 32'(r));
    chk("stable_literal", 32'(stable), 32'(st));
    chk("busy_with_result", 32'(busy), 32'd0);
`ifdef EVO_TOGGLE_COUNT_EN
    chk("toggle_literal", 32'(toggle_cnt), 32'(tg));
`else
    if (tg < 0) chk("toggle_arg", 32'(tg), 32'd0);
`endif
    @(posedge clk); #1;
    chk("result_valid_one_cycle", 32'(result_valid), 32'd0);
    chk("result_held", 32'(result), 32'(r));
  endtask

  logic [G-1:0] g_xor, g_osc;

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_bit = 1'b0; in_v = '0; eval_start = 1'b0;
    g_xor = mk(4, 0, 1, 7, 15, 0, 2);
    g_osc = mk(6, 2, 0, 7, 15, 0, 2);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // eval_start with no genome is ignored
    eval_start = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("nocfg_busy", 32'(busy), 32'd0);
      chk("nocfg_rv", 32'(result_valid), 32'd0);
      chk("nocfg_configured", 32'(configured), 32'd0);
    end
    eval_start = 1'b0;

    // XOR gate selected onto output 0
    load_bits(g_xor, G - 1, 81);
    run_eval(2'b01, 1'b1, 1'b1, 1);
    run_eval(2'b11, 1'b0, 1'b1, 0);

    // self-looped inverter oscillates
    load_bits(g_osc, G - 1, 81);
    run_eval(2'b00, 1'b0, 1'b0, 16);

    // reset in the middle of an evaluation
    eval_start = 1'b1;
    @(posedge clk); #1;
    eval_start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_configured", 32'(configured), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    eval_start = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_eval_ignored", 32'(busy), 32'd0);
    end
    eval_start = 1'b0;

    // cfg and eval_start together in READY: cfg wins
    load_bits(g_xor, G - 1, 81);
    cfg_valid  = 1'b1;
    cfg_bit    = g_osc[G-1];
    eval_start = 1'b1;
    @(posedge clk); #1;
    eval_start = 1'b0;
    chk("collide_configured", 32'(configured), 32'd0);
    chk("collide_busy", 32'(busy), 32'd0);
    load_bits(g_osc, G - 2, 80);
    run_eval(2'b00, 1'b0, 1'b0, 16);

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/evo_array_eval.md
Name: evo_array_eval

Overview:
- Parametrised, runtime-configurable successor to the fixed evolved gate netlists.
- A genome, shifted in serially, selects each gate's function and its two sources from the primary inputs and the gate outputs.
- Gate feedback goes through synchronous state registers rather than free-running cells, so evaluation is deterministic and cycle-counted.
- Sits between the genome loader/GA host and the fitness scorer; each evaluation returns the output vector and a stability (oscillation) flag.

Parameters:
- NUM_INPUTS, 2, primary input count.
- NUM_GATES, 7, gate/state-register count.
- NUM_OUTPUTS, 1, output count.
- SETTLE_CYCLES, 16, state updates per evaluation (>=2).
- Derived, not overridable:
  - N = NUM_INPUTS+NUM_GATES.
  - SEL_W = $clog2(N).
  - GW = 3+2*SEL_W.
  - G = NUM_GATES*GW + NUM_OUTPUTS*SEL_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  genome bit valid.
- cfg_bit  in  1  genome bit, MSB first.
- cfg_ready  out  1  genome bit accepted when cfg_valid&cfg_ready.
- cfg_done  out  1  one-cycle pulse when bit G has been accepted.
- configured  out  1  a complete genome is held.
- in  in  NUM_INPUTS  primary inputs, sampled on eval_start acceptance.
- eval_start  in  1  start request; accepted only in READY.
- busy  out  1  high in EVAL.
- result_valid  out  1  one-cycle pulse.
- result  out  NUM_OUTPUTS  selected gate values; held until next result_valid.
- stable  out  1  last state update produced no change; held with result.

Behaviour:
- Interface fixed: one clock, clk; reset synchronous and active-high, port named reset.
- Reset values:
  - state=UNCFG; cnt=0, bitcnt=0.
  - w, genome, in_q all 0.
  - cfg_done=0, configured=0, busy=0, result_valid=0, result=0, stable=0.
- Genome layout (genome[G-1:0]):
  - First accepted bit lands in bit G-1; each accept shifts left, cfg_bit enters bit 0.
  - Gate k field at [k*GW +: GW]: [2:0]=func, [SEL_W+2:3]=srcA, [2*SEL_W+2:SEL_W+3]=srcB.
  - Output j select at [NUM_GATES*GW + j*SEL_W +: SEL_W].
- Source index space:
  - 0..NUM_INPUTS-1 = in_q.
  - NUM_INPUTS..N-1 = w[idx-NUM_INPUTS].
  - idx>=N reads constant 0.
- func encoding: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 BUF A (B ignored for 6/7).
- States:
  - UNCFG: cfg_ready=1; an accept goes to LOAD.
  - LOAD: cfg_ready=1; on the G-th accept, set configured=1, pulse cfg_done, go to READY.
  - READY: cfg_ready=1.
    - An accepted bit clears configured, sets bitcnt=1, goes to LOAD (reload restarts).
    - eval_start (with no cfg accept) goes to EVAL.
    - If both arrive in the same cycle, cfg wins and eval_start is ignored.
  - EVAL: cfg_ready=0, busy=1.
    - Every edge: w <= F(w, in_q), all gates updated concurrently from the previous w; cnt++.
    - After SETTLE_CYCLES updates, go to READY.
- Evaluation timing:
  - Accept at edge E0: in_q<=in, w<=0, cnt<=0.
  - Updates occur at edges E1..E_SETTLE_CYCLES.
  - Edge E_SETTLE_CYCLES also registers result=sel(F(w)) and stable=(F(w)==w), and asserts result_valid for exactly one cycle.
  - Result latency is SETTLE_CYCLES edges after acceptance; busy deasserts in the same cycle result_valid rises.
- eval_start while UNCFG, LOAD or EVAL is ignored, with no queuing.
- reset mid-load or mid-eval aborts immediately to reset values; the genome is discarded.

Optional Feature:
- Macro EVO_TOGGLE_COUNT_EN.
- When defined:
  - Adds output toggle_cnt, width $clog2(SETTLE_CYCLES+1).
  - Counts updates during EVAL in which output 0's selected value changed.
  - Cleared on eval_start acceptance and on reset; valid and held alongside result.
- When undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset, then eval_start=1 for 3 cycles with no genome -> busy stays 0, no result_valid, configured=0.
- Load gate0=XOR(src0,src1), other gates BUF of index 15 (const 0), out0 select=2; in=2'b01, eval -> cfg_done pulses after 81 bits; result_valid exactly 16 cycles after accept; result=1, stable=1. Repeat with in=2'b11 -> result=0, stable=1.
- Gate0=NOT A with srcA=2 (self-loop), out0=2, SETTLE_CYCLES=16 -> result=0, stable=0; with EVO_TOGGLE_COUNT_EN, toggle_cnt=16.
- Same oscillator with SETTLE_CYCLES=15 -> result=1, stable=0; toggle_cnt=15.
- Assert reset at cycle 5 of an EVAL -> next cycle busy=0, configured=0, result=0; a following eval_start is ignored until a full reload.
- In READY, drive cfg_valid and eval_start in the same cycle -> configured drops, no EVAL entered; after 80 more bits cfg_done pulses and the new genome evaluates correctly.
